counter_sequencer: RTL and testbench
====================================

# counter_sequencer

Run controller for the 4-bit binary counter. It latches a terminal value and a mode on a start request, then drives the counter's enable and clear lines. It watches the counter output and generates one-shot or periodic terminal ticks, with pause, stop and a wrapping period tally. It sits between a software-facing control register and the counter, and owns every enable and clear the counter receives.

## Interface
- `W`, 4: counter width; must match the counter's `count` width.
- `TW`, 8: width of the completed-period tally.
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset for all state.
- `start`  in  1  run request, sampled each edge.
- `stop`  in  1  abort request, sampled each edge.
- `pause`  in  1  level; holds counting while high in RUN.
- `mode`  in  1  0 = one-shot, 1 = periodic; latched on start acceptance.
- `period`  in  W  terminal count P; latched on start acceptance.
- `count_in`  in  W  counter output.
- `cnt_en`  out  1  counter enable.
- `cnt_clr`  out  1  registered clear, wired to the counter's reset input.
- `busy`  out  1  high in CLEAR or RUN.
- `tick`  out  1  one-cycle pulse on reaching P.
- `done`  out  1  one-shot completion flag, level.
- `tick_cnt`  out  TW  completed periods since the last accepted start.

## Operation
- States: IDLE, CLEAR, RUN, DONE. Reset enters IDLE.
- **IDLE**
  - `start` & !`stop` → CLEAR.
  - Latch `mode_q`/`period_q`; zero `tick_cnt`.
- **CLEAR**
  - `cnt_clr`=1 for exactly this one cycle.
  - → RUN unconditionally, unless `stop` is high.
- **RUN**
  - `cnt_en` = RUN & !`pause` & (`count_in` != `period_q`). This output is combinational from the state register and `count_in`.
  - On `count_in` == `period_q` with !`stop`:
    - pulse `tick` and increment `tick_cnt` (wraps 2^TW−1 → 0);
    - `mode_q`=1 → CLEAR; `mode_q`=0 → DONE and set `done`.
  - `pause` does not block match detection.
  - `start` in RUN or CLEAR is ignored; latched values are unchanged.
- **DONE**
  - `done`=1, `cnt_en`=0, counter holds P.
  - `start` → CLEAR (restart: relatch inputs, clear `done`, zero `tick_cnt`).
  - `stop` → IDLE (clears `done`).
- **`stop`**, from any state: → IDLE at the next edge.
  - No clear is issued; the counter retains its value.
  - `tick_cnt` is retained.
  - `stop` beats `start` and beats a simultaneous match: no `tick` is issued.
- `busy` is decoded combinationally from state.
- P=0 is legal:
  - RUN matches on its first cycle; `cnt_en` never asserts.
  - Periodic mode ticks every 2 cycles.
- P=2^W−1 is legal: the counter stops at 15 and never wraps under this controller.

## Timing
- Reset values:
  - state=IDLE;
  - `cnt_clr`, `tick`, `done`, `busy`, `cnt_en` = 0;
  - `tick_cnt`=0;
  - `mode_q`/`period_q` = 0.
- `reset` asserted mid-run returns to IDLE immediately (asynchronous). The counter has its own reset.
- Start accepted at edge E0:
  - `cnt_clr` high from E0 to E1; `busy` high from E0.
  - RUN from E1; first increment at E2, so `count_in`=k after E(k+1).
- Match is visible after E(P+1). At E(P+2), `tick` (registered) goes high for one cycle, together with `done` (one-shot) or `cnt_clr` (periodic).
- Periodic cadence: `tick` every P+2 cycles; counter sequence is 0,1,…,P,0(clear),1,…
- One-shot: `done` rises P+2 cycles after the start edge; `busy` falls on the same edge.
- With `pause`: each paused RUN cycle adds exactly one cycle of latency.

## Test plan
- Periodic, P=3: start, hold 22 cycles.
  - Counter must run 0,1,2,3,0,…
  - `tick` at cycles 5,10,15,20 after the start edge.
  - `tick_cnt`=4; `cnt_en` low while `count_in`=3.
- One-shot, P=5: start.
  - `done`=1 and `tick` pulse at E7; count holds 5; `busy`=0 thereafter.
  - Second `start` in DONE restarts with `done` cleared and `tick_cnt`=0.
- Pause: one-shot P=4; `pause` high for 3 cycles after count reaches 2.
  - Count holds at 2 for those 3 cycles.
  - `done` at E9 instead of E6.
- Stop/start collisions:
  - `stop`+`start` together in IDLE → remains IDLE.
  - `stop` in the match cycle (P=6, periodic) → IDLE, no `tick`, count holds 6.
  - `start` during RUN → ignored; a new `period` value is not adopted.
- Boundaries:
  - P=0 periodic: `tick` every 2 cycles; `cnt_en` never high.
  - P=15 one-shot: `done` at E17, count=15 with no wrap.
  - 256 periodic ticks → `tick_cnt` wraps to 0.
- Async reset: assert `reset` mid-RUN, off-edge.
  - All outputs drop to 0 within the same timestep.
  - After release: IDLE, and a fresh start behaves as in the first scenario.

Source files
------------

// File: rtl/counter_sequencer_if.sv
// Control, status and counter-facing signals of the counter run controller.
interface counter_sequencer_if #(
    parameter int unsigned W  = 4,
    parameter int unsigned TW = 8
) ();
    logic          start;
    logic          stop;
    logic          pause;
    logic          mode;
    logic [W-1:0]  period;
    logic [W-1:0]  count_in;
    logic          cnt_en;
    logic          cnt_clr;
    logic          busy;
    logic          tick;
    logic          done;
    logic [TW-1:0] tick_cnt;

    // Software/counter side: drives requests and the counter value.
    modport master (
        output start, stop, pause, mode, period, count_in,
        input  cnt_en, cnt_clr, busy, tick, done, tick_cnt
    );

    // Sequencer side.
    modport slave (
        input  start, stop, pause, mode, period, count_in,
        output cnt_en, cnt_clr, busy, tick, done, tick_cnt
    );
endinterface

// File: rtl/counter_sequencer.sv
// Run controller for a W-bit binary counter: clears and enables the counter,
// detects the terminal count and produces one-shot or periodic ticks.
module counter_sequencer #(
    parameter int unsigned W  = 4,
    parameter int unsigned TW = 8
) (
    input  logic               clk,
    input  logic               reset,
    counter_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic [W-1:0]  period_q, period_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_q, tick_d;
    logic          cnt_clr_q, cnt_clr_d;
    logic          done_q, done_d;
    logic          match;

    assign match = (bus.count_in == period_q);

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            period_q   <= '0;
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            cnt_clr_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            period_q   <= period_d;
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
            cnt_clr_q  <= cnt_clr_d;
            done_q     <= done_d;
        end
    end

    // Next-state and next-register logic; stop overrides every other request.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        period_d   = period_q;
        tick_cnt_d = tick_cnt_q;
        tick_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = CLEAR;
                    mode_d     = bus.mode;
                    period_d   = bus.period;
                    tick_cnt_d = '0;
                end
            end
            CLEAR: state_d = RUN;
            RUN: begin
                if (match) begin
                    state_d    = mode_q ? CLEAR : DONE;
                    tick_d     = 1'b1;
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d    = CLEAR;
                    mode_d     = bus.mode;
                    period_d   = bus.period;
                    tick_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.stop) begin
            state_d    = IDLE;
            mode_d     = mode_q;
            period_d   = period_q;
            tick_cnt_d = tick_cnt_q;
            tick_d     = 1'b0;
        end

        cnt_clr_d = (state_d == CLEAR);
        done_d    = (state_d == DONE);
    end

    // Counter enable and busy decode directly from state.
    assign bus.cnt_en   = (state_q == RUN) & ~bus.pause & ~match;
    assign bus.busy     = (state_q == CLEAR) | (state_q == RUN);
    assign bus.cnt_clr  = cnt_clr_q;
    assign bus.tick     = tick_q;
    assign bus.done     = done_q;
    assign bus.tick_cnt = tick_cnt_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural 4-bit counter.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count = 4'd0;
    int         n_checks = 0;
    int         n_fails  = 0;

    counter_sequencer_if #(.W(4), .TW(8)) bus ();

    counter_sequencer #(.W(4), .TW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Counter under control: async clear from cnt_clr, count on cnt_en.
    always @(posedge clk or posedge bus.cnt_clr) begin
        if (bus.cnt_clr) count <= 4'd0;
        else if (bus.cnt_en) count <= count + 4'd1;
    end
    assign bus.count_in = count;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL reset busy got %b exp 0", bus.busy); end
        n_checks++; if (bus.cnt_clr !== 1'b0 || bus.cnt_en !== 1'b0) begin n_fails++; $display("FAIL reset clr/en got %b/%b exp 0/0", bus.cnt_clr, bus.cnt_en); end
        n_checks++; if (bus.tick !== 1'b0 || bus.done !== 1'b0) begin n_fails++; $display("FAIL reset tick/done got %b/%b exp 0/0", bus.tick, bus.done); end
        n_checks++; if (bus.tick_cnt !== 8'd0) begin n_fails++; $display("FAIL reset tick_cnt got %0d exp 0", bus.tick_cnt); end
        reset = 1'b0;
        step();
        n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL reset idle busy got %b exp 0", bus.busy); end
    endtask

    // Periodic P=3 run observed for k edges after the start edge.
    task automatic run_periodic3(input string name, input int ncyc);
        int j;
        logic [3:0] exp_cnt;
        bus.mode = 1'b1; bus.period = 4'd3; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_checks++; if (bus.cnt_clr !== 1'b1 || bus.busy !== 1'b1) begin n_fails++; $display("FAIL %s E0 clr/busy got %b/%b exp 1/1", name, bus.cnt_clr, bus.busy); end
        n_checks++; if (count !== 4'd0 || bus.tick_cnt !== 8'd0) begin n_fails++; $display("FAIL %s E0 count/tick_cnt got %0d/%0d exp 0/0", name, count, bus.tick_cnt); end
        for (int k = 1; k <= ncyc; k++) begin
            step();
            j = k % 5;
            exp_cnt = (j == 0) ? 4'd0 : 4'(j - 1);
            n_checks++; if (bus.tick !== (j == 0)) begin n_fails++; $display("FAIL %s tick E%0d got %b exp %b", name, k, bus.tick, (j == 0)); end
            n_checks++; if (count !== exp_cnt) begin n_fails++; $display("FAIL %s count E%0d got %0d exp %0d", name, k, count, exp_cnt); end
            n_checks++; if (bus.cnt_en !== (j >= 1 && j <= 3)) begin n_fails++; $display("FAIL %s cnt_en E%0d got %b exp %b", name, k, bus.cnt_en, (j >= 1 && j <= 3)); end
        end
        n_checks++; if (bus.tick_cnt !== 8'(ncyc / 5)) begin n_fails++; $display("FAIL %s tick_cnt got %0d exp %0d", name, bus.tick_cnt, ncyc / 5); end
        go_idle();
    endtask

    task automatic test_periodic();
        run_periodic3("periodic", 22);
        n_checks++; if (bus.busy !== 1'b0 || bus.tick_cnt !== 8'd4) begin n_fails++; $display("FAIL periodic stop busy/tick_cnt got %b/%0d exp 0/4", bus.busy, bus.tick_cnt); end
    endtask

    task automatic test_oneshot();
        bus.mode = 1'b0; bus.period = 4'd5; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            n_checks++; if (bus.done !== (k >= 7)) begin n_fails++; $display("FAIL oneshot done E%0d got %b exp %b", k, bus.done, (k >= 7)); end
            n_checks++; if (bus.tick !== (k == 7)) begin n_fails++; $display("FAIL oneshot tick E%0d got %b exp %b", k, bus.tick, (k == 7)); end
            n_checks++; if (bus.busy !== (k < 7)) begin n_fails++; $display("FAIL oneshot busy E%0d got %b exp %b", k, bus.busy, (k < 7)); end
        end
        n_checks++; if (count !== 4'd5 || bus.tick_cnt !== 8'd1) begin n_fails++; $display("FAIL oneshot hold count/tick_cnt got %0d/%0d exp 5/1", count, bus.tick_cnt); end
        bus.period = 4'd2; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_checks++; if (bus.done !== 1'b0 || bus.tick_cnt !== 8'd0) begin n_fails++; $display("FAIL restart done/tick_cnt got %b/%0d exp 0/0", bus.done, bus.tick_cnt); end
        n_checks++; if (bus.cnt_clr !== 1'b1 || bus.busy !== 1'b1) begin n_fails++; $display("FAIL restart clr/busy got %b/%b exp 1/1", bus.cnt_clr, bus.busy); end
        repeat (4) step();
        n_checks++; if (bus.done !== 1'b1 || count !== 4'd2 || bus.tick_cnt !== 8'd1) begin n_fails++; $display("FAIL restart end done/count/tick_cnt got %b/%0d/%0d exp 1/2/1", bus.done, count, bus.tick_cnt); end
        go_idle();
        n_checks++; if (bus.done !== 1'b0) begin n_fails++; $display("FAIL oneshot stop done got %b exp 0", bus.done); end
    endtask

    task automatic test_pause();
        bus.mode = 1'b0; bus.period = 4'd4; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        n_checks++; if (count !== 4'd2) begin n_fails++; $display("FAIL pause pre count got %0d exp 2", count); end
        bus.pause = 1'b1;
        for (int k = 4; k <= 6; k++) begin
            step();
            n_checks++; if (count !== 4'd2 || bus.cnt_en !== 1'b0) begin n_fails++; $display("FAIL pause hold E%0d count/en got %0d/%b exp 2/0", k, count, bus.cnt_en); end
        end
        bus.pause = 1'b0;
        for (int k = 7; k <= 9; k++) begin
            step();
            n_checks++; if (bus.done !== (k == 9)) begin n_fails++; $display("FAIL pause done E%0d got %b exp %b", k, bus.done, (k == 9)); end
        end
        n_checks++; if (count !== 4'd4) begin n_fails++; $display("FAIL pause final count got %0d exp 4", count); end
        go_idle();
    endtask

    task automatic test_collisions();
        bus.mode = 1'b1; bus.period = 4'd3; bus.start = 1'b1; bus.stop = 1'b1;
        step();
        bus.start = 1'b0; bus.stop = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.cnt_clr !== 1'b0) begin n_fails++; $display("FAIL start+stop busy/clr got %b/%b exp 0/0", bus.busy, bus.cnt_clr); end
        step();
        n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL start+stop later busy got %b exp 0", bus.busy); end

        bus.mode = 1'b1; bus.period = 4'd6; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (7) step();
        n_checks++; if (count !== 4'd6 || bus.cnt_en !== 1'b0) begin n_fails++; $display("FAIL stopmatch pre count/en got %0d/%b exp 6/0", count, bus.cnt_en); end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        n_checks++; if (bus.tick !== 1'b0 || bus.tick_cnt !== 8'd0) begin n_fails++; $display("FAIL stopmatch tick/tick_cnt got %b/%0d exp 0/0", bus.tick, bus.tick_cnt); end
        n_checks++; if (bus.busy !== 1'b0 || bus.cnt_clr !== 1'b0) begin n_fails++; $display("FAIL stopmatch busy/clr got %b/%b exp 0/0", bus.busy, bus.cnt_clr); end
        step();
        n_checks++; if (count !== 4'd6) begin n_fails++; $display("FAIL stopmatch hold count got %0d exp 6", count); end

        bus.mode = 1'b0; bus.period = 4'd3; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (2) step();
        bus.start = 1'b1; bus.period = 4'd9; bus.mode = 1'b1;
        step();
        bus.start = 1'b0;
        n_checks++; if (count !== 4'd2 || bus.cnt_clr !== 1'b0) begin n_fails++; $display("FAIL runstart E3 count/clr got %0d/%b exp 2/0", count, bus.cnt_clr); end
        step();
        n_checks++; if (bus.done !== 1'b0) begin n_fails++; $display("FAIL runstart E4 done got %b exp 0", bus.done); end
        step();
        n_checks++; if (bus.done !== 1'b1 || bus.tick !== 1'b1 || count !== 4'd3) begin n_fails++; $display("FAIL runstart E5 done/tick/count got %b/%b/%0d exp 1/1/3", bus.done, bus.tick, count); end
        step();
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.tick_cnt !== 8'd1) begin n_fails++; $display("FAIL runstart E6 busy/done/tick_cnt got %b/%b/%0d exp 0/1/1", bus.busy, bus.done, bus.tick_cnt); end
        go_idle();
    endtask

    task automatic test_boundaries();
        logic [7:0] exp_tc;
        bus.mode = 1'b1; bus.period = 4'd0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= 512; k++) begin
            step();
            exp_tc = 8'((k / 2) % 256);
            n_checks++; if (bus.tick !== (k % 2 == 0)) begin n_fails++; $display("FAIL p0 tick E%0d got %b exp %b", k, bus.tick, (k % 2 == 0)); end
            n_checks++; if (bus.cnt_en !== 1'b0) begin n_fails++; $display("FAIL p0 cnt_en E%0d got %b exp 0", k, bus.cnt_en); end
            n_checks++; if (bus.tick_cnt !== exp_tc) begin n_fails++; $display("FAIL p0 tick_cnt E%0d got %0d exp %0d", k, bus.tick_cnt, exp_tc); end
        end
        n_checks++; if (count !== 4'd0) begin n_fails++; $display("FAIL p0 count got %0d exp 0", count); end
        go_idle();

        bus.mode = 1'b0; bus.period = 4'd15; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            step();
            n_checks++; if (bus.done !== (k >= 17)) begin n_fails++; $display("FAIL p15 done E%0d got %b exp %b", k, bus.done, (k >= 17)); end
            if (k == 16) begin
                n_checks++; if (count !== 4'd15) begin n_fails++; $display("FAIL p15 E16 count got %0d exp 15", count); end
            end
        end
        n_checks++; if (count !== 4'd15 || bus.busy !== 1'b0) begin n_fails++; $display("FAIL p15 end count/busy got %0d/%b exp 15/0", count, bus.busy); end
        go_idle();
    endtask

    task automatic test_async_reset();
        bus.mode = 1'b1; bus.period = 4'd3; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        n_checks++; if (bus.cnt_en !== 1'b1 || bus.busy !== 1'b1) begin n_fails++; $display("FAIL areset pre en/busy got %b/%b exp 1/1", bus.cnt_en, bus.busy); end
        #3;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.cnt_en !== 1'b0 || bus.busy !== 1'b0 || bus.cnt_clr !== 1'b0) begin n_fails++; $display("FAIL areset en/busy/clr got %b/%b/%b exp 0/0/0", bus.cnt_en, bus.busy, bus.cnt_clr); end
        n_checks++; if (bus.tick !== 1'b0 || bus.done !== 1'b0 || bus.tick_cnt !== 8'd0) begin n_fails++; $display("FAIL areset tick/done/tick_cnt got %b/%b/%0d exp 0/0/0", bus.tick, bus.done, bus.tick_cnt); end
        #2;
        reset = 1'b0;
        step();
        n_checks++; if (bus.busy !== 1'b0 || bus.cnt_clr !== 1'b0) begin n_fails++; $display("FAIL areset idle busy/clr got %b/%b exp 0/0", bus.busy, bus.cnt_clr); end
        run_periodic3("post_reset", 10);
    endtask

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.pause  = 1'b0;
        bus.mode   = 1'b0;
        bus.period = 4'd0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_pause();
        test_collisions();
        test_boundaries();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
